wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Register file that consumes the write-back value selected by the upstream 8-bit 2:1 mux (ALU result vs. load data) in the Part_1 datapath.
- Provides 2 asynchronous read ports, 1 synchronous write port and a per-register busy scoreboard. Decode uses the scoreboard to detect read-after-write hazards on in-flight writes.
- Register 0 is hardwired to zero, RISC-V style.

Parameters:
- DATA_W, 8, width of each register and of the write-back data.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (8).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe from the write-back stage.
- wr_addr  input  ADDR_W  destination register of the write.
- wr_data  input  DATA_W  write-back data (upstream mux out).
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data  output  DATA_W  read port 1 data.
- rs2_data  output  DATA_W  read port 2 data.
- issue_en  input  1  decode issues an instruction that will write issue_addr.
- issue_addr  input  ADDR_W  destination being claimed.
- rs1_busy  output  1  rs1_addr has a pending (claimed, unwritten) write.
- rs2_busy  output  1  rs2_addr has a pending write.
- busy_cnt  output  ADDR_W+1  number of registers currently busy (0..NUM_REGS-1).

Behaviour:
- Reset (rst=1 at posedge): all registers := 0, all busy bits := 0, busy_cnt := 0. Reset overrides wr_en and issue_en in the same cycle.
- Outputs right after reset: rs1_data and rs2_data read 0 for every address; rs1_busy, rs2_busy and busy_cnt are 0.
- Write:
  - On posedge with wr_en=1 and wr_addr!=0: reg[wr_addr] := wr_data.
  - wr_addr=0: the write is ignored and reg[0] stays 0.
- Read:
  - Combinational; rs_data = reg[rs_addr].
  - Address 0 always returns 0.
  - Write-through bypass: if wr_en=1, wr_addr==rs_addr and rs_addr!=0, rs_data = wr_data in the same cycle (zero-latency forwarding).
- Scoreboard, evaluated per posedge:
  - set = issue_en && issue_addr!=0.
  - clr = wr_en && wr_addr!=0.
  - set on addr A: busy[A] := 1.
  - clr on addr B: busy[B] := 0.
  - Simultaneous set and clr on the same address: set wins, busy stays/becomes 1 (the newer instruction claims it).
  - Set on an already busy register: busy stays 1; no counting of multiple claims.
  - Clr on a non-busy register: no effect and no error.
- Busy outputs:
  - rs_busy = busy[rs_addr] & ~(clr && wr_addr==rs_addr); the bypassed value resolves the hazard this cycle.
  - Address 0 is never busy.
- busy_cnt: registered population count of busy bits. It updates the same edge as the busy bits and equals popcount(busy) at all times after the edge.
- Width rules:
  - wr_data is stored as is; no sign extension.
  - busy_cnt is wide enough for NUM_REGS-1 and has no wrap.
- Reset mid-operation: pending busy bits and register contents are discarded on the reset edge. Bypass still applies combinationally during reset, but nothing is stored.
- No X propagation: every output is defined from the first clock after reset.

Test Plan:
- Reset then read: assert rst for 2 cycles, then read rs1_addr=0..7 -> rs1_data=0, rs2_data=0, busy_cnt=0 for all.
- Write/read and x0:
  - wr_en=1, wr_addr=3, wr_data=8'hA5; next cycle rs1_addr=3 -> 8'hA5.
  - wr_addr=0, wr_data=8'hFF -> rs2_addr=0 reads 8'h00.
- Bypass: in the same cycle, wr_en=1, wr_addr=5, wr_data=8'h3C and rs1_addr=5 -> rs1_data=8'h3C before the edge; reg[5] still holds its old value internally.
- Scoreboard set/clear:
  - issue_en with issue_addr=2 -> next cycle busy_cnt=1 and rs1_busy=1 with rs1_addr=2.
  - wr_en, wr_addr=2 -> rs1_busy=0 combinationally; busy_cnt=0 after the edge.
- Simultaneous set and clr on addr 4 (both already busy) -> busy[4]=1 and busy_cnt unchanged. Issuing addr 0 -> busy_cnt unchanged.
- Reset mid-operation: claim regs 1, 2, 3 and write reg 6=8'h11, then rst=1 with wr_en=1 -> busy_cnt=0, reg6 reads 0, and the write during reset is not stored.
- Randomized background: 200 cycles of random wr/issue/read against a reference model; compare the data, busy and busy_cnt outputs every cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// Purpose : write-back register file (x0 hardwired to zero) with a per-register busy scoreboard.
// Latency : reads and busy flags are combinational with same-cycle write bypass; writes, busy bits, busy_cnt update on the clk edge.
// Backpressure: none; every write and issue is accepted in the cycle it is presented.
// Ports   : clk/rst (sync, active-high); wr_en/wr_addr/wr_data write port;
//           rs1_addr/rs2_addr -> rs1_data/rs2_data read ports;
//           issue_en/issue_addr claim a destination; rs1_busy/rs2_busy, busy_cnt scoreboard status.
module wb_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                wr_live;
  logic                issue_live;

  // Writes and claims to x0 are discarded, so x0 can never be stored or busy.
  assign wr_live    = wr_en && (wr_addr != '0);
  assign issue_live = issue_en && (issue_addr != '0);

  // Next busy vector: clear first, then set, so a new claim beats a retiring write.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_live) set_vec[issue_addr] = 1'b1;
    if (wr_live)    clr_vec[wr_addr]    = 1'b1;
    busy_nxt = (busy & ~clr_vec) | set_vec;
  end

  // Population count of the next busy vector, registered alongside the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_live) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports: x0 reads zero; a live write to the same register is forwarded.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wr_live && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (wr_live && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
    end
  end

  // A register being written this cycle is not reported busy: the bypass already supplies its value.
  assign rs1_busy = busy[rs1_addr] & ~(wr_live && (wr_addr == rs1_addr));
  assign rs2_busy = busy[rs2_addr] & ~(wr_live && (wr_addr == rs2_addr));

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rs1_addr;
  logic [2:0] rs2_addr;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic       issue_en;
  logic [2:0] issue_addr;
  logic       rs1_busy;
  logic       rs2_busy;
  logic [3:0] busy_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state: register contents and set of claimed registers.
  logic [7:0] m_regs [8];
  bit         m_busy [8];

  wb_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: reset discards everything; otherwise write retires, then a claim marks busy.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 8'h00;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 3'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_addr != 3'd0) m_busy[issue_addr] = 1'b1;
    end
  end

  function automatic logic [7:0] exp_data(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [3:0] exp_cnt();
    int n = 0;
    foreach (m_busy[i]) if (m_busy[i]) n++;
    return 4'(n);
  endfunction

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rs1_data", 32'(rs1_data), 32'(exp_data(rs1_addr)));
      chk("m_rs2_data", 32'(rs2_data), 32'(exp_data(rs2_addr)));
      chk("m_rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
      chk("m_rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
      chk("m_busy_cnt", 32'(busy_cnt), 32'(exp_cnt()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    issue_en = 1'b0; issue_addr = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state on every address.
    for (int a = 0; a < 8; a++) begin
      rs1_addr = 3'(a);
      rs2_addr = 3'(7 - a);
      @(negedge clk);
      chk("rst_rs1_data", 32'(rs1_data), 32'h0);
      chk("rst_rs2_data", 32'(rs2_data), 32'h0);
      chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
      tick();
    end

    // Plain write then read.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    idle(); rs1_addr = 3'd3;
    @(negedge clk);
    chk("wr3_read", 32'(rs1_data), 32'hA5);

    // Write to x0 is neither forwarded nor stored.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rs2_addr = 3'd0;
    @(negedge clk);
    chk("x0_bypass", 32'(rs2_data), 32'h00);
    tick();
    idle();
    @(negedge clk);
    chk("x0_read", 32'(rs2_data), 32'h00);

    // Same-cycle bypass, then the stored value.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C; rs1_addr = 3'd5; rs2_addr = 3'd3;
    @(negedge clk);
    chk("bypass5", 32'(rs1_data), 32'h3C);
    chk("other_port", 32'(rs2_data), 32'hA5);
    tick();
    idle();
    @(negedge clk);
    chk("stored5", 32'(rs1_data), 32'h3C);

    // Claim x2, then retire it.
    issue_en = 1'b1; issue_addr = 3'd2;
    tick();
    idle(); rs1_addr = 3'd2;
    @(negedge clk);
    chk("claim2_cnt", 32'(busy_cnt), 32'd1);
    chk("claim2_busy", 32'(rs1_busy), 32'd1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77;
    @(negedge clk);
    chk("retire2_busy", 32'(rs1_busy), 32'd0);
    chk("retire2_data", 32'(rs1_data), 32'h77);
    tick();
    idle();
    @(negedge clk);
    chk("retire2_cnt", 32'(busy_cnt), 32'd0);

    // Busy {4,6}; then set and clear on x4 together: set wins.
    issue_en = 1'b1; issue_addr = 3'd4;
    tick();
    issue_addr = 3'd6;
    tick();
    issue_en = 1'b1; issue_addr = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44; rs1_addr = 3'd4;
    @(negedge clk);
    chk("setclr_comb_busy", 32'(rs1_busy), 32'd0);
    chk("setclr_pre_cnt", 32'(busy_cnt), 32'd2);
    tick();
    idle();
    @(negedge clk);
    chk("setclr_busy4", 32'(rs1_busy), 32'd1);
    chk("setclr_cnt", 32'(busy_cnt), 32'd2);
    issue_en = 1'b1; issue_addr = 3'd0;
    tick();
    idle();
    @(negedge clk);
    chk("issue_x0_cnt", 32'(busy_cnt), 32'd2);

    // Claim 1,2,3 and write x6, then reset with a write and claim pending.
    for (int a = 1; a <= 3; a++) begin
      issue_en = 1'b1; issue_addr = 3'(a);
      tick();
    end
    idle();
    @(negedge clk);
    chk("claim123_cnt", 32'(busy_cnt), 32'd5);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h11;
    tick();
    idle(); rs1_addr = 3'd6; rs2_addr = 3'd3;
    @(negedge clk);
    chk("wr6_read", 32'(rs1_data), 32'h11);
    chk("wr6_cnt", 32'(busy_cnt), 32'd4);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h99;
    issue_en = 1'b1; issue_addr = 3'd5;
    @(negedge clk);
    chk("rst_bypass", 32'(rs1_data), 32'h99);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("midrst_cnt", 32'(busy_cnt), 32'd0);
    chk("midrst_reg6", 32'(rs1_data), 32'h00);
    chk("midrst_reg3", 32'(rs2_data), 32'h00);
    chk("midrst_busy3", 32'(rs2_busy), 32'd0);

    // Random background traffic, checked by the model every cycle.
    for (int c = 0; c < 200; c++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 8'($urandom_range(0, 255));
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = 3'($urandom_range(0, 7));
      rs1_addr   = 3'($urandom_range(0, 7));
      rs2_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      tick();
    end
    idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
